// File: rtl/simon_pkg.sv
// Shared Simon Says types, LED constants and colour decode.
// SIMON_PLAYER_FLASH_EN adds the end-of-playback all-lamps FLASH state.
package simon_pkg;

    localparam int unsigned MAX_SEQ = 16;

    typedef logic [1:0] colour_t;

    typedef enum logic [1:0] {
        StIdle,
        StOn,
`ifdef SIMON_PLAYER_FLASH_EN
        StOff,
        StFlash
`else
        StOff
`endif
    } player_state_t;

    localparam logic [3:0] LED_OFF = 4'b0000;
    localparam logic [3:0] LED_C0  = 4'b0001;
    localparam logic [3:0] LED_C1  = 4'b0010;
    localparam logic [3:0] LED_C2  = 4'b0100;
    localparam logic [3:0] LED_C3  = 4'b1000;
    localparam logic [3:0] LED_ALL = 4'b1111;

    function automatic logic [3:0] colour_to_led(input colour_t c);
        logic [3:0] led;
        unique case (c)
            2'b00:   led = LED_C0;
            2'b01:   led = LED_C1;
            2'b10:   led = LED_C2;
            default: led = LED_C3;
        endcase
        return led;
    endfunction

endpackage

// File: rtl/simon_phase_timer.sv
// Loadable down-counter; expired_o is high while the count sits at zero.
module simon_phase_timer #(
    parameter int unsigned TIMER_W = 24
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic [TIMER_W-1:0] load_val_i,
    output logic               expired_o
);

    logic [TIMER_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/simon_seq_player.sv
// Plays a latched packed colour sequence on one-hot LEDs with programmable on/off timing.
// Optional macro SIMON_PLAYER_FLASH_EN appends an all-lamps FLASH phase before done.
module simon_seq_player
    import simon_pkg::*;
#(
    parameter int unsigned ON_CYCLES  = 4,
    parameter int unsigned OFF_CYCLES = 2,
    parameter int unsigned TIMER_W    = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] seq_val,
    input  logic [3:0]  seq_len,
    output logic [3:0]  led,
    output logic [1:0]  colour_out,
    output logic        colour_valid,
    output logic        busy,
    output logic        done
);

    localparam logic [TIMER_W-1:0] ON_LOAD  = TIMER_W'(ON_CYCLES - 1);
    localparam logic [TIMER_W-1:0] OFF_LOAD = TIMER_W'(OFF_CYCLES - 1);

    player_state_t state_q, state_d;
    logic [3:0]    idx_q, idx_d;
    logic [3:0]    len_q, len_d;
    logic [31:0]   seq_q, seq_d;

    logic [3:0]    led_q, led_d;
    colour_t       colour_q, colour_d;
    logic          cvalid_q, cvalid_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic               tmr_load;
    logic [TIMER_W-1:0] tmr_val;
    logic               tmr_expired;
    colour_t            cur_colour;

    simon_phase_timer #(
        .TIMER_W(TIMER_W)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (tmr_load),
        .load_val_i(tmr_val),
        .expired_o (tmr_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            len_q   <= '0;
            seq_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            seq_q   <= seq_d;
        end
    end

    // abort outranks timer expiry in every active state
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        seq_d   = seq_q;
        unique case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    state_d = StOn;
                    seq_d   = seq_val;
                    len_d   = seq_len;
                    idx_d   = '0;
                end
            end
            StOn: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (tmr_expired) begin
                    state_d = StOff;
                end
            end
            StOff: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (tmr_expired) begin
                    if (idx_q == len_q) begin
`ifdef SIMON_PLAYER_FLASH_EN
                        state_d = StFlash;
`else
                        state_d = StIdle;
`endif
                    end else begin
                        state_d = StOn;
                        idx_d   = idx_q + 1'b1;
                    end
                end
            end
`ifdef SIMON_PLAYER_FLASH_EN
            StFlash: begin
                if (abort || tmr_expired) begin
                    state_d = StIdle;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    // Outputs are registered from the next state so they change on the same edge as the FSM.
    always_comb begin
        tmr_load   = (state_d != state_q);
        tmr_val    = '0;
        cur_colour = seq_d[{idx_d, 1'b0} +: 2];
        led_d      = LED_OFF;
        colour_d   = '0;
        cvalid_d   = 1'b0;
        busy_d     = (state_d != StIdle);
        done_d     = (state_q != StIdle) && (state_d == StIdle) && !abort;
        unique case (state_d)
            StOn: begin
                tmr_val  = ON_LOAD;
                led_d    = colour_to_led(cur_colour);
                colour_d = cur_colour;
                cvalid_d = 1'b1;
            end
            StOff: tmr_val = OFF_LOAD;
`ifdef SIMON_PLAYER_FLASH_EN
            StFlash: begin
                tmr_val = ON_LOAD;
                led_d   = LED_ALL;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_q    <= LED_OFF;
            colour_q <= '0;
            cvalid_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            led_q    <= led_d;
            colour_q <= colour_d;
            cvalid_q <= cvalid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign led          = led_q;
    assign colour_out   = colour_q;
    assign colour_valid = cvalid_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_simon_seq_player.sv
// Scoreboard bench for simon_seq_player: expected per-cycle outputs queued, monitor compares.
module tb_simon_seq_player;

    localparam int unsigned ON_C  = 4;
    localparam int unsigned OFF_C = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] seq_val = '0;
    logic [3:0]  seq_len = '0;
    logic [3:0]  led;
    logic [1:0]  colour_out;
    logic        colour_valid;
    logic        busy;
    logic        done;

    int tests = 0;
    int fails = 0;

    // entry layout: {led[3:0], colour[1:0], valid, busy, done}
    logic [8:0] exp_q[$];

    simon_seq_player #(
        .ON_CYCLES (ON_C),
        .OFF_CYCLES(OFF_C),
        .TIMER_W   (24)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .seq_val     (seq_val),
        .seq_len     (seq_len),
        .led         (led),
        .colour_out  (colour_out),
        .colour_valid(colour_valid),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] dec(input logic [1:0] c);
        case (c)
            2'b00:   return 4'b0001;
            2'b01:   return 4'b0010;
            2'b10:   return 4'b0100;
            default: return 4'b1000;
        endcase
    endfunction

    // Queue the first 'limit' cycles of a normal playback of (sv, len).
    task automatic push_trace(input logic [31:0] sv, input logic [3:0] len, input int limit);
        logic [8:0] tq[$];
        logic [31:0] s;
        logic [1:0] c;
        s = sv;
        for (int k = 0; k <= int'(len); k++) begin
            c = s[2*k +: 2];
            for (int i = 0; i < int'(ON_C); i++) tq.push_back({dec(c), c, 1'b1, 1'b1, 1'b0});
            for (int i = 0; i < int'(OFF_C); i++) tq.push_back({4'b0000, 2'b00, 1'b0, 1'b1, 1'b0});
        end
`ifdef SIMON_PLAYER_FLASH_EN
        for (int i = 0; i < int'(ON_C); i++) tq.push_back({4'b1111, 2'b00, 1'b0, 1'b1, 1'b0});
`endif
        tq.push_back({4'b0000, 2'b00, 1'b0, 1'b0, 1'b1});
        for (int i = 0; i < tq.size() && i < limit; i++) exp_q.push_back(tq[i]);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic start_pulse(input logic [31:0] sv, input logic [3:0] len);
        @(posedge clk);
        #1;
        seq_val = sv;
        seq_len = len;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0 && !busy && !done) break;
        end
        repeat (3) @(posedge clk);
        #1;
        check({name, "_drain_left"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    // Monitor: every cycle the DUT shows activity must match the next queued entry.
    always @(negedge clk) begin
        logic [8:0] act;
        logic [8:0] e;
        if (rst_n && (busy || done || colour_valid || led != 4'b0000)) begin
            act = {led, colour_out, colour_valid, busy, done};
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_activity: got %h, expected idle", act);
            end else begin
                e = exp_q.pop_front();
                if (!e[2]) begin
                    act[4:3] = 2'b00;
                    e[4:3]   = 2'b00;
                end
                if (act !== e) begin
                    fails++;
                    $display("FAIL cycle_outputs: got %h, expected %h", act, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        #12;
        check("reset_led", 32'(led), 32'h0);
        check("reset_colour", 32'(colour_out), 32'h0);
        check("reset_flags", 32'({colour_valid, busy, done}), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // single colour 10 -> 0100
        push_trace(32'h0000_0002, 4'd0, 1000);
        start_pulse(32'h0000_0002, 4'd0);
        drain("single", 40);

        // full 16-colour sequence
        push_trace(32'hE4E4_E4E4, 4'd15, 1000);
        start_pulse(32'hE4E4_E4E4, 4'd15);
        drain("full", 200);

        // inputs changed mid-play are ignored
        push_trace(32'h0000_001B, 4'd3, 1000);
        start_pulse(32'h0000_001B, 4'd3);
        repeat (5) @(posedge clk);
        #1;
        seq_val = 32'hFFFF_FFFF;
        seq_len = 4'd15;
        drain("latched", 100);

        // abort during the third colour's ON phase
        push_trace(32'h0000_00E4, 4'd3, 14);
        start_pulse(32'h0000_00E4, 4'd3);
        repeat (13) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort_led", 32'(led), 32'h0);
        check("abort_flags", 32'({colour_valid, busy, done}), 32'h0);
        drain("abort", 20);

        // start with abort in idle is ignored
        @(posedge clk);
        #1;
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        check("abort_start_idle", 32'(busy), 32'h0);
        drain("abort_start", 10);

        // new start after abort
        push_trace(32'h0000_0039, 4'd2, 1000);
        start_pulse(32'h0000_0039, 4'd2);
        drain("post_abort", 60);

        // start held high: done then immediate replay
        push_trace(32'h0000_0006, 4'd1, 1000);
        push_trace(32'h0000_0006, 4'd1, 1000);
        @(posedge clk);
        #1;
        seq_val = 32'h0000_0006;
        seq_len = 4'd1;
        start = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        start = 1'b0;
        drain("held_start", 80);

        // async reset in the OFF gap
        push_trace(32'h0000_0001, 4'd0, int'(ON_C));
        start_pulse(32'h0000_0001, 4'd0);
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_led", 32'(led), 32'h0);
        check("rst_flags", 32'({colour_valid, busy, done}), 32'h0);
        check("rst_queue", 32'(exp_q.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        drain("post_reset", 10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/simon_seq_player.md
Name: simon_seq_player

Overview:
Playback side of the Simon Says colour path. The capture block assembles a packed 32-bit sequence of 2-bit colours from user presses; this block reads such a sequence back and flashes it on four one-hot LEDs with programmable on/off timing. It signals completion so the game controller can arm capture for the player's response.

Parameters:
ON_CYCLES, 4, clock cycles each colour is lit (must be >= 1)
OFF_CYCLES, 2, clock cycles of dark gap after each colour (must be >= 1)
TIMER_W, 24, phase timer width; must hold max(ON_CYCLES, OFF_CYCLES)-1

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
start  input  1  level sampled each cycle; begins playback when idle
abort  input  1  synchronous cancel of playback in progress
seq_val  input  32  packed sequence; colour k = seq_val[2k+1:2k], k=0 played first
seq_len  input  4  number of colours minus one (0 -> 1 colour, 15 -> 16 colours)
led  output  4  one-hot lamp drive, registered
colour_out  output  2  colour currently shown, registered
colour_valid  output  1  high while a colour is lit
busy  output  1  high from cycle after accepted start until return to IDLE
done  output  1  one-cycle pulse on normal completion

Behaviour:
- Reset (async, rst_n=0): state IDLE, led=0000, colour_out=00, colour_valid=0, busy=0, done=0, index=0, timer=0, latched sequence/length=0.
- Colour decode: 00->0001, 01->0010, 10->0100, 11->1000; led=0000 whenever colour_valid=0.
- States IDLE, ON, OFF.
- IDLE: start=1 at edge t -> latch seq_val/seq_len, index=0, enter ON. led/colour_valid/busy high from t+1 (1-cycle latency).
- ON: colour index shown for exactly ON_CYCLES cycles, then OFF.
- OFF: dark for exactly OFF_CYCLES cycles. At expiry:
  - index==latched length: done=1 for one cycle; same edge enters IDLE, busy=0.
  - Otherwise index+1, enter ON.
- Total playback for N colours = N*(ON_CYCLES+OFF_CYCLES) cycles; done asserted in the cycle after the last OFF cycle.
- Inputs latched at start; changes to seq_val/seq_len during playback are ignored.
- start while busy is ignored; no queuing. start held high through completion restarts on the first IDLE cycle, so done and the next busy are back-to-back.
- abort=1 in ON/OFF: next edge -> IDLE, outputs cleared, no done pulse. abort has priority over timer expiry. abort in IDLE has no effect; abort and start together in IDLE -> start ignored.
- Timer: counts down from load value; expiry when timer==0. Reloaded on every state entry.
- rst_n low mid-playback: immediate return to reset values, no done.

Optional Feature:
SIMON_PLAYER_FLASH_EN:
- Defined: after the final OFF, extra state FLASH lights led=1111 for ON_CYCLES cycles with colour_valid=0 and busy=1. done pulses on FLASH expiry. abort applies in FLASH.
- Undefined: FLASH state and its logic are absent; timing as above.

Decomposition:
- Shared package simon_pkg:
  - colour_t (2-bit) typedef
  - player state enum
  - LED one-hot constants
  - colour_to_led function, shared with the capture block
  - MAX_SEQ=16
- One sub-module, simon_phase_timer: loadable down-counter, TIMER_W wide, with load value input, load strobe, and expired flag.

Test Plan:
- Single colour: seq_len=0, seq_val[1:0]=10, start one cycle -> led=0100 for 4 cycles, then 0000 for 2 cycles, done pulse at cycle 7, busy high for cycles 1-6.
- Full sequence: seq_len=15, seq_val=32'hE4E4_E4E4 -> led order 0001,0010,0100,1000 repeated four times; done after exactly 96 cycles.
- Input change ignored: change seq_val and seq_len mid-play -> original latched pattern and length complete unchanged.
- Abort: abort asserted in 3rd colour's ON -> next cycle IDLE, led=0000, busy=0, no done; a new start then works normally.
- Start held high continuously with seq_len=1 -> done pulse, then immediate replay (busy re-asserted the following cycle).
- Async reset mid-OFF: rst_n low between edges -> outputs zero immediately, no done; with SIMON_PLAYER_FLASH_EN also check 1111 for 4 cycles before done.
